// File: rtl/return_addr_stack_pkg.sv
// Shared core constants for the return-address stack and its neighbours
// (PC incrementer, PC register).
//   ADDR_W    : architectural address width.
//   RAS_DEPTH : default number of return-address stack entries.
package return_addr_stack_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned RAS_DEPTH = 8;

endpackage

// File: rtl/return_addr_stack_if.sv
// Request/status bundle between the fetch stage and the return-address stack.
//   master : fetch side, drives flush/push/push_addr/pop/clr_flags.
//   slave  : stack side, drives top_addr/count/empty/full/overflow/underflow.
interface return_addr_stack_if
  import return_addr_stack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ADDR_W,
  parameter int unsigned DEPTH      = RAS_DEPTH
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic                  flush;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_addr;
  logic                  pop;
  logic                  clr_flags;
  logic [DATA_WIDTH-1:0] top_addr;
  logic [PTR_W:0]        count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, push, push_addr, pop, clr_flags,
    input  top_addr, count, empty, full, overflow, underflow
  );

  modport slave (
    input  flush, push, push_addr, pop, clr_flags,
    output top_addr, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/return_addr_stack_ptr_ctrl.sv
// Stack pointer, occupancy count and sticky flag control for the
// return-address stack. Tells the storage array where (and whether) to write.
//   clk, rst_n            : clock, async active-low reset
//   flush_i, push_i, pop_i, clr_flags_i : operation requests
//   sp_o                  : next write slot
//   count_o, empty_o, full_o : occupancy
//   overflow_o, underflow_o  : sticky error flags
//   wr_en_o, wr_idx_o     : storage write strobe and slot
module ras_ptr_ctrl
  import return_addr_stack_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clr_flags_i,
  output logic [PTR_W-1:0] sp_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             wr_en_o,
  output logic [PTR_W-1:0] wr_idx_o
);

  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);

  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             ovf_set, udf_set;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntFull);

  always_comb begin
    sp_d     = sp_q;
    count_d  = count_q;
    wr_en_o  = 1'b0;
    wr_idx_o = sp_q;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;

    if (flush_i) begin
      sp_d    = '0;
      count_d = '0;
    end else if (push_i && pop_i) begin
      if (!empty_o) begin
        // Replace the top entry in place; occupancy is unchanged.
        wr_en_o  = 1'b1;
        wr_idx_o = sp_q - PtrOne;
      end else begin
        wr_en_o = 1'b1;
        sp_d    = sp_q + PtrOne;
        count_d = count_q + CntOne;
        udf_set = 1'b1;
      end
    end else if (push_i) begin
      // When full the write slot holds the oldest entry, so it is overwritten.
      wr_en_o = 1'b1;
      sp_d    = sp_q + PtrOne;
      if (full_o) begin
        ovf_set = 1'b1;
      end else begin
        count_d = count_q + CntOne;
      end
    end else if (pop_i) begin
      if (!empty_o) begin
        sp_d    = sp_q - PtrOne;
        count_d = count_q - CntOne;
      end else begin
        udf_set = 1'b1;
      end
    end

    // A set in the same cycle as a clear wins.
    ovf_d = (ovf_q & ~clr_flags_i) | ovf_set;
    udf_d = (udf_q & ~clr_flags_i) | udf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign sp_o        = sp_q;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack beside the fetch stage. Calls push PC+1 from the
// incrementer; returns read it back through top_addr to the PC-select mux.
// Circular storage: pushing while full overwrites the oldest entry.
//   clk, rst_n : clock, async active-low reset
//   bus_io     : slave side of return_addr_stack_if (requests in, status out)
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ADDR_W,
  parameter int unsigned DEPTH      = RAS_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  return_addr_stack_if.slave   bus_io
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      sp;
  logic [PTR_W-1:0]      wr_idx;
  logic [PTR_W-1:0]      top_idx;
  logic                  wr_en;
  logic                  empty;

  ras_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (bus_io.flush),
    .push_i      (bus_io.push),
    .pop_i       (bus_io.pop),
    .clr_flags_i (bus_io.clr_flags),
    .sp_o        (sp),
    .count_o     (bus_io.count),
    .empty_o     (empty),
    .full_o      (bus_io.full),
    .overflow_o  (bus_io.overflow),
    .underflow_o (bus_io.underflow),
    .wr_en_o     (wr_en),
    .wr_idx_o    (wr_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= bus_io.push_addr;
    end
  end

  // Flush leaves stale entries behind, so gate the read with empty.
  assign top_idx         = sp - PtrOne;
  assign bus_io.top_addr = empty ? '0 : mem_q[top_idx];
  assign bus_io.empty    = empty;

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;
  import return_addr_stack_pkg::*;

  localparam int unsigned DW    = ADDR_W;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  return_addr_stack_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  return_addr_stack #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: newest entry at the back of the queue.
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_udf;

  function automatic logic [DW-1:0] m_top();
    return (mq.size() > 0) ? mq[$] : '0;
  endfunction

  function automatic logic [CNT_W-1:0] m_cnt();
    return CNT_W'(mq.size());
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step(input bit f, input bit pu, input logic [DW-1:0] pa,
                            input bit po, input bit cl);
    bit ovf_set = 1'b0;
    bit udf_set = 1'b0;
    if (f) begin
      mq.delete();
    end else if (pu && po) begin
      if (mq.size() > 0) mq[mq.size()-1] = pa;
      else begin mq.push_back(pa); udf_set = 1'b1; end
    end else if (pu) begin
      if (mq.size() == DEPTH) begin void'(mq.pop_front()); ovf_set = 1'b1; end
      mq.push_back(pa);
    end else if (po) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else udf_set = 1'b1;
    end
    m_ovf = (m_ovf && !cl) || ovf_set;
    m_udf = (m_udf && !cl) || udf_set;
  endtask

  // One clock: drive, advance model at the edge, return 1 time unit later.
  task automatic cycle(input bit f, input bit pu, input logic [DW-1:0] pa,
                       input bit po, input bit cl);
    bus.flush = f; bus.push = pu; bus.push_addr = pa; bus.pop = po; bus.clr_flags = cl;
    @(posedge clk);
    model_step(f, pu, pa, po, cl);
    #1;
    bus.flush = 1'b0; bus.push = 1'b0; bus.push_addr = '0; bus.pop = 1'b0;
    bus.clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    n_cmp++;
    if ({bus.top_addr, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow} !==
        {{DW{1'b0}}, {CNT_W{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_held: top=%h cnt=%0d e=%b f=%b o=%b u=%b required 0/0/1/0/0/0",
               bus.top_addr, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow);
    end
    rst_n = 1'b1;
    cycle(0, 0, '0, 0, 0);
    cycle(0, 0, '0, 0, 0);
    n_cmp++;
    if (bus.top_addr !== '0 || bus.count !== '0 || bus.empty !== 1'b1 ||
        bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: top=%h cnt=%0d e=%b o=%b u=%b required 0/0/1/0/0",
               bus.top_addr, bus.count, bus.empty, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_lifo();
    logic [DW-1:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    logic [DW-1:0] after_pop [3] = '{32'h22, 32'h11, 32'h0};
    foreach (vals[i]) begin
      cycle(0, 1, vals[i], 0, 0);
      n_cmp++;
      if (bus.top_addr !== vals[i] || bus.count !== m_cnt()) begin
        n_err++;
        $display("FAIL lifo_push%0d: top=%h cnt=%0d required %h/%0d",
                 i, bus.top_addr, bus.count, vals[i], m_cnt());
      end
    end
    foreach (after_pop[i]) begin
      cycle(0, 0, '0, 1, 0);
      n_cmp++;
      if (bus.top_addr !== after_pop[i] || bus.count !== CNT_W'(2 - i)) begin
        n_err++;
        $display("FAIL lifo_pop%0d: top=%h cnt=%0d required %h/%0d",
                 i, bus.top_addr, bus.count, after_pop[i], 2 - i);
      end
    end
    n_cmp++;
    if (bus.empty !== 1'b1 || bus.underflow !== 1'b0) begin
      n_err++;
      $display("FAIL lifo_empty: e=%b u=%b required 1/0", bus.empty, bus.underflow);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 1, DW'(i), 0, 0);
      n_cmp++;
      if (bus.full !== (i >= 4) || bus.overflow !== (i == 5) || bus.count !== m_cnt()) begin
        n_err++;
        $display("FAIL ovf_push%0d: full=%b ovf=%b cnt=%0d required %b/%b/%0d",
                 i, bus.full, bus.overflow, bus.count, i >= 4, i == 5, m_cnt());
      end
    end
    for (int i = 5; i >= 2; i--) begin
      n_cmp++;
      if (bus.top_addr !== DW'(i)) begin
        n_err++;
        $display("FAIL ovf_pop_top: got %h required %h", bus.top_addr, DW'(i));
      end
      cycle(0, 0, '0, 1, 0);
    end
    n_cmp++;
    if (bus.empty !== 1'b1 || bus.top_addr !== '0 || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drained: e=%b top=%h ovf=%b required 1/0/1",
               bus.empty, bus.top_addr, bus.overflow);
    end
  endtask

  task automatic test_underflow();
    cycle(0, 0, '0, 1, 0);
    n_cmp++;
    if (bus.underflow !== 1'b1 || bus.count !== '0 || bus.top_addr !== '0) begin
      n_err++;
      $display("FAIL udf_set: u=%b cnt=%0d top=%h required 1/0/0",
               bus.underflow, bus.count, bus.top_addr);
    end
    cycle(0, 0, '0, 0, 1);
    n_cmp++;
    if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL udf_clear: u=%b o=%b required 0/0", bus.underflow, bus.overflow);
    end
    // Clear and a new underflow in the same cycle: the set wins.
    cycle(0, 0, '0, 1, 1);
    n_cmp++;
    if (bus.underflow !== m_udf) begin
      n_err++;
      $display("FAIL udf_set_wins: got %b required %b", bus.underflow, m_udf);
    end
    cycle(0, 0, '0, 0, 1);
  endtask

  task automatic test_push_pop();
    cycle(0, 1, 32'hA, 0, 0);
    cycle(0, 1, 32'hB, 0, 0);
    cycle(0, 1, 32'hC, 1, 0);
    n_cmp++;
    if (bus.count !== CNT_W'(2) || bus.top_addr !== 32'hC) begin
      n_err++;
      $display("FAIL pushpop_replace: cnt=%0d top=%h required 2/0000000c",
               bus.count, bus.top_addr);
    end
    cycle(0, 0, '0, 1, 0);
    n_cmp++;
    if (bus.top_addr !== 32'hA || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_err++;
      $display("FAIL pushpop_pop: top=%h o=%b u=%b required 0000000a/0/0",
               bus.top_addr, bus.overflow, bus.underflow);
    end
    cycle(0, 0, '0, 1, 0);
    // Push with pop on empty behaves as a push but flags underflow.
    cycle(0, 1, 32'hD, 1, 0);
    n_cmp++;
    if (bus.top_addr !== m_top() || bus.count !== m_cnt() || bus.underflow !== m_udf) begin
      n_err++;
      $display("FAIL pushpop_empty: top=%h cnt=%0d u=%b required %h/%0d/%b",
               bus.top_addr, bus.count, bus.underflow, m_top(), m_cnt(), m_udf);
    end
    cycle(0, 0, '0, 1, 1);
  endtask

  task automatic test_flush_reset();
    cycle(0, 1, 32'h7, 0, 0);
    cycle(0, 1, 32'h7, 0, 0);
    cycle(1, 1, 32'h9, 0, 0);
    n_cmp++;
    if (bus.count !== '0 || bus.empty !== 1'b1 || bus.top_addr !== '0) begin
      n_err++;
      $display("FAIL flush: cnt=%0d e=%b top=%h required 0/1/0",
               bus.count, bus.empty, bus.top_addr);
    end
    cycle(0, 1, 32'h5, 0, 0);
    cycle(0, 1, 32'h6, 0, 0);
    cycle(0, 1, 32'h7, 0, 0);
    cycle(0, 1, 32'h8, 0, 0);
    cycle(0, 1, 32'h9, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (bus.top_addr !== '0 || bus.count !== '0 || bus.full !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.empty !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: top=%h cnt=%0d f=%b o=%b e=%b required 0/0/0/0/1",
               bus.top_addr, bus.count, bus.full, bus.overflow, bus.empty);
    end
    #3;
    rst_n = 1'b1;
    cycle(0, 1, 32'hE, 0, 0);
    cycle(0, 1, 32'hF, 0, 0);
    cycle(0, 0, '0, 1, 0);
    n_cmp++;
    if (bus.top_addr !== 32'hE || bus.count !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL post_reset_push: top=%h cnt=%0d required 0000000e/1",
               bus.top_addr, bus.count);
    end
  endtask

  task automatic test_random();
    bit f, pu, po, cl;
    logic [DW-1:0] pa;
    for (int n = 0; n < 400; n++) begin
      f  = ($urandom_range(0, 19) == 0);
      pu = ($urandom_range(0, 1) == 1);
      po = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 9) == 0);
      pa = $urandom();
      cycle(f, pu, pa, po, cl);
      n_cmp++;
      if (bus.top_addr !== m_top()) begin
        n_err++;
        $display("FAIL rnd_top[%0d]: got %h required %h", n, bus.top_addr, m_top());
      end
      n_cmp++;
      if (bus.count !== m_cnt() || bus.empty !== (mq.size() == 0) ||
          bus.full !== (mq.size() == DEPTH)) begin
        n_err++;
        $display("FAIL rnd_occ[%0d]: cnt=%0d e=%b f=%b required %0d", n, bus.count,
                 bus.empty, bus.full, m_cnt());
      end
      n_cmp++;
      if (bus.overflow !== m_ovf || bus.underflow !== m_udf) begin
        n_err++;
        $display("FAIL rnd_flags[%0d]: o=%b u=%b required %b/%b", n, bus.overflow,
                 bus.underflow, m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    bus.flush = 1'b0; bus.push = 1'b0; bus.push_addr = '0; bus.pop = 1'b0;
    bus.clr_flags = 1'b0;
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_push_pop();
    test_flush_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
